// File: rtl/full_adder_if.sv
// Bit-level adder bundle: operand/control inputs plus combinational and registered results.
// The slave modport is the adder itself; the master modport is whoever drives the operands.
interface full_adder_if;
    logic A;
    logic B;
    logic C;
    logic en;
    logic serial;
    logic clr;
    logic Sum;
    logic Carry;
    logic sum_q;
    logic carry_q;
    logic valid_q;

    modport master (
        output A, B, C, en, serial, clr,
        input  Sum, Carry, sum_q, carry_q, valid_q
    );

    modport slave (
        input  A, B, C, en, serial, clr,
        output Sum, Carry, sum_q, carry_q, valid_q
    );
endinterface

// File: rtl/full_adder.sv
// Full adder with a zero-latency combinational path and a one-cycle registered path that can chain its carry for bit-serial addition.
// Latency: Sum/Carry 0 cycles, sum_q/carry_q/valid_q 1 cycle; no backpressure, en simply gates capture.
module full_adder #(
    parameter logic CARRY_INIT = 1'b0
) (
    input logic        clk,
    input logic        rst_n,
    full_adder_if.slave bus
);
    logic cin_sel;
    logic sum_d;
    logic carry_d;
    logic sum_r;
    logic carry_r;
    logic valid_r;

    // Combinational path deliberately touches nothing clocked or reset-related.
    assign bus.Sum   = bus.A ^ bus.B ^ bus.C;
    assign bus.Carry = (bus.A & bus.B) | (bus.A & bus.C) | (bus.B & bus.C);

    always_comb begin
        cin_sel = bus.serial ? carry_r : bus.C;
        sum_d   = bus.A ^ bus.B ^ cin_sel;
        carry_d = (bus.A & bus.B) | (bus.A & cin_sel) | (bus.B & cin_sel);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r   <= 1'b0;
            carry_r <= CARRY_INIT;
            valid_r <= 1'b0;
        end else if (bus.clr) begin
            sum_r   <= 1'b0;
            carry_r <= CARRY_INIT;
            valid_r <= 1'b0;
        end else if (bus.en) begin
            sum_r   <= sum_d;
            carry_r <= carry_d;
            valid_r <= 1'b1;
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign bus.sum_q   = sum_r;
    assign bus.carry_q = carry_r;
    assign bus.valid_q = valid_r;
endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: combinational truth table, parallel capture, serial 11+6, mid-operation reset, clr priority.
module tb_full_adder;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic [7:0] sum_tab;
    logic [7:0] carry_tab;
    logic [2:0] abc;

    full_adder_if bus ();

    full_adder #(.CARRY_INIT(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_check(input string tag, input logic s, input logic c, input logic v);
        check({tag, ".sum_q"},   bus.sum_q,   s);
        check({tag, ".carry_q"}, bus.carry_q, c);
        check({tag, ".valid_q"}, bus.valid_q, v);
    endtask

    task automatic drive(input logic a, input logic b, input logic c);
        bus.A = a;
        bus.B = b;
        bus.C = c;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        sum_tab   = 8'b1001_0110;
        carry_tab = 8'b1110_1000;
        rst_n      = 1'b0;
        bus.en     = 1'b0;
        bus.serial = 1'b0;
        bus.clr    = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        #2;
        reg_check("reset", 1'b0, 1'b0, 1'b0);

        // Combinational path while reset is held: named vectors, then full sweep.
        drive(1'b0, 1'b0, 1'b0); #100;
        check("comb000.Sum", bus.Sum, 1'b0); check("comb000.Carry", bus.Carry, 1'b0);
        drive(1'b1, 1'b1, 1'b1); #100;
        check("comb111.Sum", bus.Sum, 1'b1); check("comb111.Carry", bus.Carry, 1'b1);
        drive(1'b1, 1'b0, 1'b0); #100;
        check("comb100.Sum", bus.Sum, 1'b1); check("comb100.Carry", bus.Carry, 1'b0);
        drive(1'b0, 1'b1, 1'b1); #100;
        check("comb011.Sum", bus.Sum, 1'b0); check("comb011.Carry", bus.Carry, 1'b1);
        for (int i = 0; i < 8; i++) begin
            abc = i[2:0];
            drive(abc[2], abc[1], abc[0]);
            #100;
            check($sformatf("sweep%0d.Sum", i),   bus.Sum,   sum_tab[i]);
            check($sformatf("sweep%0d.Carry", i), bus.Carry, carry_tab[i]);
        end
        reg_check("reset_held", 1'b0, 1'b0, 1'b0);

        // Parallel capture, then hold with en low.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b1);
        bus.en = 1'b1;
        tick();
        reg_check("par101", 1'b0, 1'b1, 1'b1);
        bus.en = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        tick();
        reg_check("par_hold", 1'b0, 1'b1, 1'b0);

        // Serial 11 + 6, LSB first; C held high to prove it is ignored.
        bus.clr = 1'b1;
        tick();
        reg_check("ser_clr", 1'b0, 1'b0, 1'b0);
        bus.clr = 1'b0; bus.serial = 1'b1; bus.en = 1'b1;
        drive(1'b1, 1'b0, 1'b1); tick(); reg_check("ser_b0", 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1); tick(); reg_check("ser_b1", 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1); tick(); reg_check("ser_b2", 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1); tick(); reg_check("ser_b3", 1'b0, 1'b1, 1'b1);

        // Restart the serial add and reset it between edges.
        bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        drive(1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0); tick();
        reg_check("mid_pre", 1'b0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        reg_check("mid_rst", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0); #1;
        check("rst_comb110.Sum", bus.Sum, 1'b0); check("rst_comb110.Carry", bus.Carry, 1'b1);
        drive(1'b0, 1'b0, 1'b1); #1;
        check("rst_comb001.Sum", bus.Sum, 1'b1); check("rst_comb001.Carry", bus.Carry, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        bus.serial = 1'b0; bus.clr = 1'b1;
        tick();
        reg_check("rst_ignores_ctl", 1'b0, 1'b0, 1'b0);

        // First capture after release, then serial toggled on uses carry_q.
        @(negedge clk);
        rst_n = 1'b1; bus.clr = 1'b0;
        tick();
        reg_check("first_cap", 1'b1, 1'b1, 1'b1);
        bus.serial = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        reg_check("serial_toggle", 1'b1, 1'b0, 1'b1);

        // clr wins over en.
        bus.serial = 1'b0;
        drive(1'b1, 1'b1, 1'b1);
        tick();
        reg_check("pre_clr", 1'b1, 1'b1, 1'b1);
        bus.clr = 1'b1;
        tick();
        reg_check("clr_over_en", 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter CARRY_INIT, default 1'b0: reset and clear value of the carry register carry_q.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for the registered path only.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 A  input  1  addend bit.
REQ-006 B  input  1  addend bit.
REQ-007 C  input  1  carry-in bit.
REQ-008 en  input  1  capture enable for the registered path.
REQ-009 serial  input  1  1 = registered path takes carry-in from carry_q instead of C (bit-serial addition).
REQ-010 clr  input  1  synchronous clear of the registered path.
REQ-011 Sum  output  1  combinational sum bit.
REQ-012 Carry  output  1  combinational carry-out bit.
REQ-013 sum_q  output  1  registered sum bit.
REQ-014 carry_q  output  1  registered carry bit; also the serial carry state.
REQ-015 valid_q  output  1  high for one cycle after each enabled capture.

Function
REQ-016 Sum SHALL equal A xor B xor C, purely combinational, zero cycle latency.
REQ-017 Carry SHALL equal (A and B) or (A and C) or (B and C), purely combinational.
REQ-018 Sum and Carry SHALL NOT depend on clk, rst_n, en, serial or clr, so they are correct with clk unconnected.
REQ-019 Registered carry-in is cin_sel = serial ? carry_q : C.
REQ-020 On a rising clk edge with clr=1: sum_q <= 0, carry_q <= CARRY_INIT, valid_q <= 0; clr SHALL take priority over en.
REQ-021 On a rising clk edge with clr=0 and en=1: sum_q <= A xor B xor cin_sel, carry_q <= majority(A, B, cin_sel), valid_q <= 1.
REQ-022 On a rising clk edge with clr=0 and en=0: sum_q and carry_q SHALL hold, and valid_q <= 0.
REQ-023 Registered-path latency SHALL be exactly one clock cycle from sampled inputs to sum_q, carry_q and valid_q.
REQ-024 In serial mode, carry_q SHALL feed the next enabled capture, so successive LSB-first bit pairs produce a ripple sum one bit per enabled cycle.
REQ-025 Toggling serial between cycles SHALL take effect on the next edge, with no extra state.

Reset
REQ-026 When rst_n=0, asynchronously and independent of clk: sum_q=0, carry_q=CARRY_INIT, valid_q=0.
REQ-027 While rst_n=0, the registered path SHALL ignore en, clr and serial.
REQ-028 The first capture SHALL occur on the first rising clk edge with rst_n=1 and en=1.
REQ-029 Reset SHALL NOT affect Sum or Carry.

Verification
REQ-030 Combinational, no clock: A,B,C = 000 -> Sum=0,Carry=0; 111 -> 1,1; 100 -> 1,0; 011 -> 0,1; each held 100 ns. Sweep all 8 combinations against REQ-016/017.
REQ-031 Registered parallel, serial=0, en=1: A=1,B=0,C=1 -> next edge sum_q=0, carry_q=1, valid_q=1; then en=0 -> values hold, valid_q=0.
REQ-032 Serial add 11+6: clr for one cycle, then serial=1, en=1, LSB first, A bits 1,1,0,1 and B bits 0,1,1,0 -> sum_q sequence 1,0,0,0, final carry_q=1 (result 17).
REQ-033 Reset mid-operation: assert rst_n=0 between edges during the serial add -> sum_q=0, carry_q=CARRY_INIT, valid_q=0 immediately; Sum and Carry keep tracking A,B,C.
REQ-034 Simultaneous clr=1 and en=1 with A=B=C=1 -> next edge sum_q=0, carry_q=CARRY_INIT, valid_q=0.
